// File: rtl/memory_stage.sv
// MIPS memory-access stage: EX/MEM and MEM/WB pipeline registers, word-addressed data memory,
// branch resolution and write-back select.
module memory_stage #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic        ZERO,
    input  logic [31:0] AddResult,
    input  logic [31:0] ALUReadData2_Out,
    input  logic [4:0]  RdOrRt,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    // EX/MEM register
    logic        ex_valid;
    logic [31:0] ex_alu;
    logic        ex_zero;
    logic [31:0] ex_add;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        ex_branch;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] mem_idx;
    logic              misaligned;
    logic              store_en;
    logic [31:0]       load_data;
    logic              wb_valid_d;
    logic              wb_reg_write_d;
    logic [31:0]       wb_data_d;
    logic              mem_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu        <= '0;
            ex_zero       <= 1'b0;
            ex_add        <= '0;
            ex_wdata      <= '0;
            ex_rd         <= '0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            ex_valid      <= in_valid;
            ex_alu        <= alu_result;
            ex_zero       <= ZERO;
            ex_add        <= AddResult;
            ex_wdata      <= ALUReadData2_Out;
            ex_rd         <= RdOrRt;
            ex_branch     <= Branch;
            ex_mem_read   <= MemRead;
            ex_mem_write  <= MemWrite;
            ex_reg_write  <= RegWrite;
            ex_mem_to_reg <= MemtoReg;
        end
    end

    always_comb begin
        PCSrc         = ex_valid & ex_branch & ex_zero;
        branch_target = ex_add;
    end

    // Upper address bits are dropped, so addresses wrap modulo 4*DEPTH.
    always_comb begin
        mem_idx    = ex_alu[ADDR_W+1:2];
        misaligned = (ex_alu[1:0] != 2'b00) & (ex_mem_read | ex_mem_write);
        store_en   = ex_valid & ex_mem_write & ~misaligned;
        load_data  = misaligned ? 32'h0 : mem[mem_idx];
    end

    // A combined read+write behaves as a store and returns the address.
    always_comb begin
        wb_valid_d     = ex_valid;
        wb_reg_write_d = ex_valid & ex_reg_write & (ex_rd != 5'd0);
        wb_data_d      = (ex_mem_to_reg & ~ex_mem_write) ? load_data : ex_alu;
        mem_err_d      = ex_valid & misaligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            mem[mem_idx] <= ex_wdata;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_reg       <= ex_rd;
            wb_data      <= wb_data_d;
            mem_err      <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Table-driven, scoreboard-checked bench for memory_stage, plus a mid-operation reset sequence.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic        ZERO;
    logic [31:0] AddResult;
    logic [31:0] ALUReadData2_Out;
    logic [4:0]  RdOrRt;
    logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        wb_valid, wb_reg_write, mem_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    memory_stage #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .alu_result       (alu_result),
        .ZERO             (ZERO),
        .AddResult        (AddResult),
        .ALUReadData2_Out (ALUReadData2_Out),
        .RdOrRt           (RdOrRt),
        .Branch           (Branch),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .RegWrite         (RegWrite),
        .MemtoReg         (MemtoReg),
        .PCSrc            (PCSrc),
        .branch_target    (branch_target),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .mem_err          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        z;
        logic [31:0] add;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        br, mr, mw, rw, m2r;
        logic        e_pc;
        logic        e_rw;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic        v;
        logic        pc;
        logic [31:0] target;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    vec_t tbl[17];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic v, logic [31:0] alu, logic z, logic [31:0] add,
                                logic [31:0] wd, logic [4:0] rd, logic br, logic mr, logic mw,
                                logic rw, logic m2r, logic e_pc, logic e_rw,
                                logic [31:0] e_data, logic e_err);
        vec_t r;
        r.v = v; r.alu = alu; r.z = z; r.add = add; r.wd = wd; r.rd = rd;
        r.br = br; r.mr = mr; r.mw = mw; r.rw = rw; r.m2r = m2r;
        r.e_pc = e_pc; r.e_rw = e_rw; r.e_data = e_data; r.e_err = e_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.v; alu_result = v.alu; ZERO = v.z; AddResult = v.add;
        ALUReadData2_Out = v.wd; RdOrRt = v.rd; Branch = v.br; MemRead = v.mr;
        MemWrite = v.mw; RegWrite = v.rw; MemtoReg = v.m2r;
    endtask

    // One cycle: compare what the pipeline shows now, then drive and enqueue the next vector.
    task automatic cycle(input vec_t v);
        exp_t e;
        exp_t w;
        @(negedge clk);
        if (q.size() >= 1) begin
            check("pcsrc", {31'b0, PCSrc}, {31'b0, q[$].pc});
            if (q[$].pc) check("branch_target", branch_target, q[$].target);
        end
        if (q.size() >= 2) begin
            w = q.pop_front();
            check("wb_valid", {31'b0, wb_valid}, {31'b0, w.v});
            check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, w.rw});
            check("mem_err", {31'b0, mem_err}, {31'b0, w.err});
            if (w.v) begin
                check("wb_reg", {27'b0, wb_reg}, {27'b0, w.rd});
                check("wb_data", wb_data, w.data);
            end
        end
        drive(v);
        e.v = v.v; e.pc = v.e_pc; e.target = v.add; e.rw = v.e_rw; e.rd = v.rd;
        e.data = v.e_data; e.err = v.e_err;
        q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pcsrc"}, {31'b0, PCSrc}, 32'h0);
        check({tag, "_target"}, branch_target, 32'h0);
        check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'h0);
        check({tag, "_wb_reg_write"}, {31'b0, wb_reg_write}, 32'h0);
        check({tag, "_wb_reg"}, {27'b0, wb_reg}, 32'h0);
        check({tag, "_wb_data"}, wb_data, 32'h0);
        check({tag, "_mem_err"}, {31'b0, mem_err}, 32'h0);
    endtask

    vec_t bubble;

    initial begin
        //            v  alu       z  add       wd           rd  br mr mw rw m2r pc erw e_data       err
        tbl[0]  = mk(1, 32'd10,   0, 32'h0,    32'h0,        5,  0, 0, 0, 1, 0,  0, 1, 32'd10,      0);
        tbl[1]  = mk(1, 32'd8,    0, 32'h0,    32'hDEADBEEF, 0,  0, 0, 1, 0, 0,  0, 0, 32'd8,       0);
        tbl[2]  = mk(1, 32'd8,    0, 32'h0,    32'h0,        3,  0, 1, 0, 1, 1,  0, 1, 32'hDEADBEEF, 0);
        tbl[3]  = mk(1, 32'd12,   0, 32'h0,    32'h0,        4,  0, 1, 0, 1, 1,  0, 1, 32'h0,       0);
        tbl[4]  = mk(1, 32'd0,    1, 32'h40,   32'h0,        0,  1, 0, 0, 0, 0,  1, 0, 32'h0,       0);
        tbl[5]  = mk(1, 32'd0,    0, 32'h80,   32'h0,        0,  1, 0, 0, 0, 0,  0, 0, 32'h0,       0);
        tbl[6]  = mk(1, 32'd9,    0, 32'h0,    32'h11111111, 0,  0, 0, 1, 0, 0,  0, 0, 32'd9,       1);
        tbl[7]  = mk(1, 32'd8,    0, 32'h0,    32'h0,        1,  0, 1, 0, 1, 1,  0, 1, 32'hDEADBEEF, 0);
        tbl[8]  = mk(1, 32'd260,  0, 32'h0,    32'hCAFEF00D, 0,  0, 0, 1, 0, 0,  0, 0, 32'd260,     0);
        tbl[9]  = mk(1, 32'd4,    0, 32'h0,    32'h0,        7,  0, 1, 0, 1, 1,  0, 1, 32'hCAFEF00D, 0);
        tbl[10] = mk(1, 32'h55,   0, 32'h0,    32'h0,        0,  0, 0, 0, 1, 0,  0, 0, 32'h55,      0);
        tbl[11] = mk(0, 32'd8,    0, 32'h0,    32'h12345678, 0,  0, 0, 1, 0, 0,  0, 0, 32'h0,       0);
        tbl[12] = mk(1, 32'd8,    0, 32'h0,    32'h0,        2,  0, 1, 0, 1, 1,  0, 1, 32'hDEADBEEF, 0);
        tbl[13] = mk(1, 32'd6,    0, 32'h0,    32'h0,        6,  0, 1, 0, 1, 1,  0, 1, 32'h0,       1);
        tbl[14] = mk(1, 32'd16,   0, 32'h0,    32'h77,       8,  0, 1, 1, 1, 1,  0, 1, 32'd16,      0);
        tbl[15] = mk(1, 32'd16,   0, 32'h0,    32'h0,        9,  0, 1, 0, 1, 1,  0, 1, 32'h77,      0);
        tbl[16] = mk(1, 32'd272,  0, 32'h0,    32'h0,        10, 0, 1, 0, 1, 1,  0, 1, 32'h77,      0);
        bubble  = mk(0, 32'h0,    0, 32'h0,    32'h0,        0,  0, 0, 0, 0, 0,  0, 0, 32'h0,       0);

        rst_n = 1'b0;
        drive(bubble);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) cycle(tbl[i]);
        cycle(bubble);
        cycle(bubble);

        // Reset while a branching store to address 4 sits in EX/MEM behind a live R-type.
        q.delete();
        cycle(mk(1, 32'd99, 0, 32'h0, 32'h0, 12, 0, 0, 0, 1, 0, 0, 1, 32'd99, 0));
        cycle(mk(1, 32'd4, 1, 32'h100, 32'hAAAA5555, 0, 1, 0, 1, 0, 0, 1, 0, 32'd4, 0));
        @(posedge clk);
        #2;
        check("pre_reset_pcsrc", {31'b0, PCSrc}, 32'h1);
        check("pre_reset_wb_valid", {31'b0, wb_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        q.delete();
        drive(bubble);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Word 1 held 0xCAFEF00D before reset and the in-flight store must not land.
        cycle(mk(1, 32'd4, 0, 32'h0, 32'h0, 11, 0, 1, 0, 1, 1, 0, 1, 32'h0, 0));
        cycle(bubble);
        cycle(bubble);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
